// File: rtl/voice_alloc.sv
// voice_alloc: assigns MIDI notes to oscillator voices,
// stealing the least-recently-assigned voice when full.
`ifndef OSC_VOICES
`define OSC_VOICES 4
`endif
`ifndef MIDI_PAYLOAD_BITS
`define MIDI_PAYLOAD_BITS 8
`endif

module voice_alloc #(
   parameter int VOICES = `OSC_VOICES,
   parameter int NOTE_W = `MIDI_PAYLOAD_BITS
) (
   input  logic                     clk_i,
   input  logic                     nrst_i,
   input  logic [NOTE_W-1:0]        note_i,
   input  logic                     noteOnStrb_i,
   input  logic                     noteOffStrb_i,
   output logic [VOICES-1:0]        voiceActive_o,
   output logic [VOICES*NOTE_W-1:0] voiceNote_o,
   output logic [VOICES-1:0]        voiceTrig_o,
   output logic                     busy_o,
   output logic                     dropped_o
);

   localparam int AGE_W = $clog2(VOICES);

   typedef logic [AGE_W-1:0] idx_t;
   typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

   localparam idx_t LAST = idx_t'(VOICES - 1);

   state_t             state;
   idx_t               scanIdx;
   logic               evOn;
   logic [NOTE_W-1:0]  evNote;
   logic               matchHit;
   idx_t               matchIdx;
   logic               freeHit;
   idx_t               freeIdx;
   idx_t               oldIdx;
   idx_t               tgt;
   logic               anyStrb;
   logic [NOTE_W-1:0]  noteQ [VOICES];
   idx_t               ageQ  [VOICES];

   assign anyStrb = noteOnStrb_i | noteOffStrb_i;

   // Note-on target: retrigger a match, else a free voice, else steal.
   always_comb begin
      tgt = oldIdx;
      if (matchHit) begin
         tgt = matchIdx;
      end else if (freeHit) begin
         tgt = freeIdx;
      end
   end

   // Flatten the per-voice note registers onto the output bus.
   always_comb begin
      voiceNote_o = '0;
      for (int v = 0; v < VOICES; v++) begin
         voiceNote_o[v*NOTE_W +: NOTE_W] = noteQ[v];
      end
   end

   // Event FSM: capture, serial scan of all voices, then commit.
   always_ff @(posedge clk_i or negedge nrst_i) begin
      if (!nrst_i) begin
         state         <= IDLE;
         scanIdx       <= '0;
         evOn          <= 1'b0;
         evNote        <= '0;
         matchHit      <= 1'b0;
         matchIdx      <= '0;
         freeHit       <= 1'b0;
         freeIdx       <= '0;
         oldIdx        <= '0;
         voiceActive_o <= '0;
         voiceTrig_o   <= '0;
         busy_o        <= 1'b0;
         dropped_o     <= 1'b0;
         for (int v = 0; v < VOICES; v++) begin
            noteQ[v] <= '0;
            ageQ[v]  <= idx_t'(v);
         end
      end else begin
         voiceTrig_o <= '0;
         dropped_o   <= 1'b0;
         unique case (state)
            IDLE: begin
               if (anyStrb) begin
                  // Off wins a simultaneous on/off; the on is dropped.
                  evOn      <= ~noteOffStrb_i;
                  evNote    <= note_i;
                  dropped_o <= noteOnStrb_i & noteOffStrb_i;
                  scanIdx   <= '0;
                  matchHit  <= 1'b0;
                  matchIdx  <= '0;
                  freeHit   <= 1'b0;
                  freeIdx   <= '0;
                  oldIdx    <= '0;
                  busy_o    <= 1'b1;
                  state     <= SCAN;
               end
            end
            SCAN: begin
               dropped_o <= anyStrb;
               if (voiceActive_o[scanIdx] && !matchHit &&
                   noteQ[scanIdx] == evNote) begin
                  matchHit <= 1'b1;
                  matchIdx <= scanIdx;
               end
               if (!voiceActive_o[scanIdx] && !freeHit) begin
                  freeHit <= 1'b1;
                  freeIdx <= scanIdx;
               end
               if (ageQ[scanIdx] == LAST) begin
                  oldIdx <= scanIdx;
               end
               scanIdx <= scanIdx + 1'b1;
               if (scanIdx == LAST) begin
                  state <= COMMIT;
               end
            end
            COMMIT: begin
               dropped_o <= anyStrb;
               if (evOn) begin
                  voiceActive_o[tgt] <= 1'b1;
                  noteQ[tgt]         <= evNote;
                  voiceTrig_o[tgt]   <= 1'b1;
                  // Younger voices age by one; target becomes newest.
                  for (int v = 0; v < VOICES; v++) begin
                     if (idx_t'(v) == tgt) begin
                        ageQ[v] <= '0;
                     end else if (ageQ[v] < ageQ[tgt]) begin
                        ageQ[v] <= ageQ[v] + 1'b1;
                     end
                  end
               end else if (matchHit) begin
                  voiceActive_o[matchIdx] <= 1'b0;
               end
               busy_o <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
